// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: column drive, row sampling,
// frame-level debounce and single-shot key reporting.
module keypad_scan #(
  parameter int SCAN_BIT = 16,
  parameter int DEBOUNCE = 4
) (
  input  logic       clk,
  input  logic       rst_p,
  input  logic [3:0] row_n,
  output logic [3:0] col_n,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_down
);

  typedef enum logic {IDLE, PRESSED} state_t;

  localparam logic [3:0] DB = 4'(DEBOUNCE);

  state_t state, state_nx;

  logic [3:0] row_m, row_s;
  logic [SCAN_BIT-1:0] div;
  logic [1:0] col;
  logic sample, last_col;

  logic [1:0] row_idx;
  logic col_hit;
  logic acc_v;
  logic [3:0] acc_code;
  logic base_v, frame_v;
  logic [3:0] frame_code, res_code;

  logic prev_v;
  logic [3:0] prev_code;
  logic [3:0] cnt, cnt_nx;
  logic same, stable, load;

  assign col      = div[SCAN_BIT-1 -: 2];
  assign sample   = &div[SCAN_BIT-3:0];
  assign last_col = sample && (col == 2'd3);
  assign col_n    = ~(4'b0001 << col);

  always_ff @(posedge clk or posedge rst_p) begin
    if (rst_p) begin
      row_m <= 4'hF;
      row_s <= 4'hF;
      div   <= '0;
    end else begin
      row_m <= row_n;
      row_s <= row_m;
      div   <= div + 1'b1;
    end
  end

  // Lowest active row wins within a column.
  always_comb begin
    row_idx = 2'd0;
    col_hit = 1'b1;
    casez (row_s)
      4'b???0: row_idx = 2'd0;
      4'b??01: row_idx = 2'd1;
      4'b?011: row_idx = 2'd2;
      4'b0111: row_idx = 2'd3;
      default: col_hit = 1'b0;
    endcase
  end

  assign base_v     = (col != 2'd0) && acc_v;
  assign frame_v    = base_v || col_hit;
  assign frame_code = base_v ? acc_code : {row_idx, col};
  assign res_code   = frame_v ? frame_code : 4'd0;

  always_ff @(posedge clk or posedge rst_p) begin
    if (rst_p) begin
      acc_v    <= 1'b0;
      acc_code <= 4'd0;
    end else if (sample) begin
      acc_v    <= frame_v;
      acc_code <= frame_code;
    end
  end

  assign same = (frame_v == prev_v) && (res_code == prev_code);

  always_comb begin
    cnt_nx = 4'd1;
    if (same)
      cnt_nx = (cnt >= DB) ? cnt : cnt + 4'd1;
  end

  assign stable = (cnt_nx == DB);

  always_ff @(posedge clk or posedge rst_p) begin
    if (rst_p) begin
      prev_v    <= 1'b0;
      prev_code <= 4'd0;
      cnt       <= 4'd0;
    end else if (last_col) begin
      prev_v    <= frame_v;
      prev_code <= res_code;
      cnt       <= cnt_nx;
    end
  end

  always_ff @(posedge clk or posedge rst_p) begin
    if (rst_p) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:
        if (last_col && stable && frame_v)
          state_nx = PRESSED;
      PRESSED:
        if (last_col && stable && !frame_v)
          state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    key_down = (state == PRESSED);
    load     = (state == IDLE) && (state_nx == PRESSED);
  end

  always_ff @(posedge clk or posedge rst_p) begin
    if (rst_p) begin
      key_valid <= 1'b0;
      key_code  <= 4'd0;
    end else begin
      key_valid <= load;
      if (load) key_code <= res_code;
    end
  end

endmodule
